// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two line-level requester ports plus the
// main-memory request/grant channel and the busy flag.
// master: the arbiter's view. slave: the requesters plus memory around it.
interface mem_arbiter_if #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9
);
  localparam int LINE_WORDS = 1 << LINE_ADDR_LEN;

  // requester port 0
  logic                p0_rd_req;
  logic                p0_wr_req;
  logic [ADDR_LEN-1:0] p0_addr;
  logic [31:0]         p0_wr_line [LINE_WORDS];
  logic                p0_gnt;
  logic [31:0]         p0_rd_line [LINE_WORDS];

  // requester port 1
  logic                p1_rd_req;
  logic                p1_wr_req;
  logic [ADDR_LEN-1:0] p1_addr;
  logic [31:0]         p1_wr_line [LINE_WORDS];
  logic                p1_gnt;
  logic [31:0]         p1_rd_line [LINE_WORDS];

  // main memory channel
  logic                mem_rd_req;
  logic                mem_wr_req;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [31:0]         mem_wr_line [LINE_WORDS];
  logic                mem_gnt;
  logic [31:0]         mem_rd_line [LINE_WORDS];

  logic                busy;

  modport master (
    input  p0_rd_req, p0_wr_req, p0_addr, p0_wr_line,
    output p0_gnt, p0_rd_line,
    input  p1_rd_req, p1_wr_req, p1_addr, p1_wr_line,
    output p1_gnt, p1_rd_line,
    output mem_rd_req, mem_wr_req, mem_addr, mem_wr_line,
    input  mem_gnt, mem_rd_line,
    output busy
  );

  modport slave (
    output p0_rd_req, p0_wr_req, p0_addr, p0_wr_line,
    input  p0_gnt, p0_rd_line,
    output p1_rd_req, p1_wr_req, p1_addr, p1_wr_line,
    input  p1_gnt, p1_rd_line,
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wr_line,
    output mem_gnt, mem_rd_line,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port line-level arbiter in front of main memory.
// FSM IDLE -> MEM -> RESP -> IDLE; one transaction at a time, no queuing.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: port 0 always wins ties
// (default: round-robin, port not granted last wins, port 0 first after reset).
module mem_arbiter #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);
  localparam int LINE_WORDS = 1 << LINE_ADDR_LEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                own_reg, own_next;
  logic                mem_rd_req_reg, mem_rd_req_next;
  logic                mem_wr_req_reg, mem_wr_req_next;
  logic [ADDR_LEN-1:0] mem_addr_reg, mem_addr_next;
  logic                p0_gnt_reg, p0_gnt_next;
  logic                p1_gnt_reg, p1_gnt_next;

  // per-transaction strobes into the word datapath
  logic line_load;   // capture selected write line into mem_wr_line
  logic line_clear;  // zero mem_wr_line once memory has answered
  logic p0_load;     // capture mem_rd_line into port 0's buffer
  logic p1_load;     // capture mem_rd_line into port 1's buffer

  // arbitration
  logic                p0_any, p1_any, pick1, sel_wr;
  logic [ADDR_LEN-1:0] sel_addr;

  assign p0_any = bus.p0_rd_req | bus.p0_wr_req;
  assign p1_any = bus.p1_rd_req | bus.p1_wr_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // port 1 only wins when port 0 is silent
  assign pick1 = p1_any & ~p0_any;
`else
  // on a tie, the port that did not own the last transaction wins
  assign pick1 = p1_any & (~p0_any | ~own_reg);
`endif

  // a write request takes precedence over a read on the same port
  assign sel_wr   = pick1 ? bus.p1_wr_req : bus.p0_wr_req;
  assign sel_addr = pick1 ? bus.p1_addr   : bus.p0_addr;

  // next-state and control: grant in IDLE, wait for memory in MEM, pulse in RESP
  always_comb begin
    state_next      = state_reg;
    own_next        = own_reg;
    mem_rd_req_next = mem_rd_req_reg;
    mem_wr_req_next = mem_wr_req_reg;
    mem_addr_next   = mem_addr_reg;
    p0_gnt_next     = 1'b0;
    p1_gnt_next     = 1'b0;
    line_load       = 1'b0;
    line_clear      = 1'b0;
    p0_load         = 1'b0;
    p1_load         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (p0_any | p1_any) begin
          state_next      = MEM;
          own_next        = pick1;
          mem_wr_req_next = sel_wr;
          mem_rd_req_next = ~sel_wr;
          mem_addr_next   = sel_addr;
          line_load       = 1'b1;
        end
      end
      MEM: begin
        if (bus.mem_gnt) begin
          state_next      = RESP;
          mem_rd_req_next = 1'b0;
          mem_wr_req_next = 1'b0;
          mem_addr_next   = '0;
          line_clear      = 1'b1;
          p0_load         = mem_rd_req_reg & ~own_reg;
          p1_load         = mem_rd_req_reg & own_reg;
          p0_gnt_next     = ~own_reg;
          p1_gnt_next     = own_reg;
        end
      end
      RESP: begin
        // unconditional turnaround through IDLE so a stale request is not regranted
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // control state register; reset leaves own=1 so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      own_reg        <= 1'b1;
      mem_rd_req_reg <= 1'b0;
      mem_wr_req_reg <= 1'b0;
      mem_addr_reg   <= '0;
      p0_gnt_reg     <= 1'b0;
      p1_gnt_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      own_reg        <= own_next;
      mem_rd_req_reg <= mem_rd_req_next;
      mem_wr_req_reg <= mem_wr_req_next;
      mem_addr_reg   <= mem_addr_next;
      p0_gnt_reg     <= p0_gnt_next;
      p1_gnt_reg     <= p1_gnt_next;
    end
  end

  // word-sliced line datapath: write-line holding register and two read buffers
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      logic [31:0] sel_word;
      logic [31:0] wr_word_reg;
      logic [31:0] p0_word_reg;
      logic [31:0] p1_word_reg;

      assign sel_word = pick1 ? bus.p1_wr_line[gi] : bus.p0_wr_line[gi];

      // memory write data: valid only while MEM is active
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_word_reg <= '0;
        end else if (line_load) begin
          wr_word_reg <= sel_word;
        end else if (line_clear) begin
          wr_word_reg <= '0;
        end
      end

      // port 0 read buffer: only a read owned by port 0 may change it
      always_ff @(posedge clk) begin
        if (rst) begin
          p0_word_reg <= '0;
        end else if (p0_load) begin
          p0_word_reg <= bus.mem_rd_line[gi];
        end
      end

      // port 1 read buffer: only a read owned by port 1 may change it
      always_ff @(posedge clk) begin
        if (rst) begin
          p1_word_reg <= '0;
        end else if (p1_load) begin
          p1_word_reg <= bus.mem_rd_line[gi];
        end
      end

      assign bus.mem_wr_line[gi] = wr_word_reg;
      assign bus.p0_rd_line[gi]  = p0_word_reg;
      assign bus.p1_rd_line[gi]  = p1_word_reg;
    end
  endgenerate

  assign bus.mem_rd_req = mem_rd_req_reg;
  assign bus.mem_wr_req = mem_wr_req_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.p0_gnt     = p0_gnt_reg;
  assign bus.p1_gnt     = p1_gnt_reg;
  assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a fixed-latency memory stub (L=4).
module tb_mem_arbiter;
  localparam int LAL     = 3;
  localparam int AL      = 9;
  localparam int WORDS   = 1 << LAL;
  localparam int STUB_L  = 4;

  logic clk;
  logic rst;
  logic force_gnt;
  int   stub_cnt;

  mem_arbiter_if #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL)) bus ();

  mem_arbiter #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory stub: answers in the L-th cycle of a held request
  always @(posedge clk) begin
    if (bus.mem_rd_req || bus.mem_wr_req) stub_cnt <= stub_cnt + 1;
    else stub_cnt <= 0;
  end
  assign bus.mem_gnt = ((bus.mem_rd_req || bus.mem_wr_req) && (stub_cnt == STUB_L - 1)) || force_gnt;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // observations from the first MEM cycle of a transaction
  logic          seen_rd, seen_wr, seen_unstable;
  logic [AL-1:0] seen_addr;
  logic [31:0]   seen_w0, seen_w7;
  int            seen_idle;
  int            g_port, g_cyc, mem_cyc;
  int            rr_exp [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // advance until a grant appears; cycle 1 is the cycle the call starts in
  task automatic run_txn();
    g_port = -1; g_cyc = 0; mem_cyc = 0; seen_idle = 0; seen_unstable = 1'b0;
    seen_rd = 1'b0; seen_wr = 1'b0; seen_addr = '0; seen_w0 = '0; seen_w7 = '0;
    for (int c = 2; c <= 30 && g_port < 0; c++) begin
      tick();
      if (!bus.busy) seen_idle++;
      if (bus.mem_rd_req || bus.mem_wr_req) begin
        mem_cyc++;
        if (mem_cyc == 1) begin
          seen_rd = bus.mem_rd_req; seen_wr = bus.mem_wr_req; seen_addr = bus.mem_addr;
          seen_w0 = bus.mem_wr_line[0]; seen_w7 = bus.mem_wr_line[7];
        end else if (bus.mem_addr !== seen_addr || bus.mem_wr_line[0] !== seen_w0) begin
          seen_unstable = 1'b1;
        end
      end
      if (bus.p0_gnt || bus.p1_gnt) begin
        g_port = bus.p0_gnt ? (bus.p1_gnt ? 2 : 0) : 1;
        g_cyc  = c;
      end
    end
  endtask

  initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    rr_exp[0] = 0; rr_exp[1] = 0; rr_exp[2] = 0;
`else
    rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 0;
`endif
    rst = 1'b1; force_gnt = 1'b0;
    bus.p0_rd_req = 1'b0; bus.p0_wr_req = 1'b0; bus.p0_addr = '0;
    bus.p1_rd_req = 1'b0; bus.p1_wr_req = 1'b0; bus.p1_addr = '0;
    for (int i = 0; i < WORDS; i++) begin
      bus.p0_wr_line[i] = '0; bus.p1_wr_line[i] = '0; bus.mem_rd_line[i] = 32'(i);
    end
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_p0_gnt", bus.p0_gnt, 0);
    chk("rst_p1_gnt", bus.p1_gnt, 0);
    chk("rst_mem_rd_req", bus.mem_rd_req, 0);
    chk("rst_mem_wr_req", bus.mem_wr_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wr_line7", bus.mem_wr_line[7], 0);
    chk("rst_p0_rd_line3", bus.p0_rd_line[3], 0);
    chk("rst_p1_rd_line3", bus.p1_rd_line[3], 0);

    // port 0 line read
    bus.p0_rd_req = 1'b1; bus.p0_addr = 9'h015;
    run_txn();
    chk("rd_port", g_port, 0);
    chk("rd_gnt_cycle", g_cyc, 6);
    chk("rd_mem_cycles", mem_cyc, STUB_L);
    chk("rd_mem_rd_req", seen_rd, 1);
    chk("rd_mem_wr_req", seen_wr, 0);
    chk("rd_mem_addr", seen_addr, 9'h015);
    chk("rd_busy_resp", bus.busy, 1);
    for (int i = 0; i < WORDS; i++) chk($sformatf("rd_p0_line%0d", i), bus.p0_rd_line[i], i);
    chk("rd_p1_line_kept", bus.p1_rd_line[3], 0);
    bus.p0_rd_req = 1'b0;
    tick();
    chk("rd_idle_busy", bus.busy, 0);
    chk("rd_idle_gnt", bus.p0_gnt, 0);
    chk("rd_idle_mem_addr", bus.mem_addr, 0);

    // port 1 line write
    bus.p1_wr_req = 1'b1; bus.p1_addr = 9'h1A0;
    for (int i = 0; i < WORDS; i++) bus.p1_wr_line[i] = 32'hDEADBEEF;
    run_txn();
    chk("wr_port", g_port, 1);
    chk("wr_gnt_cycle", g_cyc, 6);
    chk("wr_mem_cycles", mem_cyc, STUB_L);
    chk("wr_mem_wr_req", seen_wr, 1);
    chk("wr_mem_rd_req", seen_rd, 0);
    chk("wr_mem_addr", seen_addr, 9'h1A0);
    chk("wr_line_w0", seen_w0, 32'hDEADBEEF);
    chk("wr_line_w7", seen_w7, 32'hDEADBEEF);
    chk("wr_mem_stable", seen_unstable, 0);
    chk("wr_p1_line_kept", bus.p1_rd_line[5], 0);
    chk("wr_p0_line_kept", bus.p0_rd_line[5], 5);
    bus.p1_wr_req = 1'b0;
    tick();
    chk("wr_idle_wr_line", bus.mem_wr_line[0], 0);

    // simultaneous reads held across three grants
    bus.p0_rd_req = 1'b1; bus.p0_addr = 9'h010;
    bus.p1_rd_req = 1'b1; bus.p1_addr = 9'h011;
    for (int k = 0; k < 3; k++) begin
      run_txn();
      chk($sformatf("rr_port%0d", k), g_port, rr_exp[k]);
      chk($sformatf("rr_cycle%0d", k), g_cyc, (k == 0) ? 6 : 7);
    end
    bus.p0_rd_req = 1'b0; bus.p1_rd_req = 1'b0;
    tick();

    // write followed immediately by a read on port 0
    bus.p0_wr_req = 1'b1; bus.p0_addr = 9'h033;
    for (int i = 0; i < WORDS; i++) bus.p0_wr_line[i] = 32'h1000 + 32'(i);
    run_txn();
    chk("swap_wr_port", g_port, 0);
    chk("swap_wr_op", seen_wr, 1);
    chk("swap_wr_w7", seen_w7, 32'h1007);
    chk("swap_wr_rdline_kept", bus.p0_rd_line[2], 2);
    bus.p0_wr_req = 1'b0; bus.p0_rd_req = 1'b1;
    for (int i = 0; i < WORDS; i++) bus.mem_rd_line[i] = 32'h100 + 32'(i);
    run_txn();
    chk("swap_rd_port", g_port, 0);
    chk("swap_rd_cycle", g_cyc, 7);
    chk("swap_rd_idle", seen_idle, 1);
    chk("swap_rd_op", seen_rd, 1);
    chk("swap_rd_line2", bus.p0_rd_line[2], 32'h102);
    bus.p0_rd_req = 1'b0;
    tick();

    // read and write raised together on port 0
    bus.p0_rd_req = 1'b1; bus.p0_wr_req = 1'b1; bus.p0_addr = 9'h077;
    for (int i = 0; i < WORDS; i++) bus.p0_wr_line[i] = 32'h55AA0000 + 32'(i);
    for (int i = 0; i < WORDS; i++) bus.mem_rd_line[i] = 32'h200 + 32'(i);
    run_txn();
    chk("both_first_wr", seen_wr, 1);
    chk("both_first_rd", seen_rd, 0);
    chk("both_first_w7", seen_w7, 32'h55AA0007);
    chk("both_first_rdline_kept", bus.p0_rd_line[2], 32'h102);
    bus.p0_wr_req = 1'b0;
    run_txn();
    chk("both_second_port", g_port, 0);
    chk("both_second_rd", seen_rd, 1);
    chk("both_second_cycle", g_cyc, 7);
    chk("both_second_line2", bus.p0_rd_line[2], 32'h202);
    bus.p0_rd_req = 1'b0;
    tick();

    // reset in the middle of MEM, then a late memory grant
    bus.p0_rd_req = 1'b1; bus.p0_addr = 9'h044;
    tick(); tick();
    chk("abort_in_mem", bus.mem_rd_req, 1);
    rst = 1'b1; bus.p0_rd_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_mem_rd_req", bus.mem_rd_req, 0);
    chk("abort_mem_addr", bus.mem_addr, 0);
    chk("abort_p0_gnt", bus.p0_gnt, 0);
    chk("abort_p0_line", bus.p0_rd_line[2], 0);
    force_gnt = 1'b1;
    tick();
    force_gnt = 1'b0;
    chk("late_gnt_p0", bus.p0_gnt, 0);
    chk("late_gnt_p1", bus.p1_gnt, 0);
    chk("late_gnt_busy", bus.busy, 0);
    tick();
    chk("late_gnt_p0_next", bus.p0_gnt, 0);
    bus.p1_rd_req = 1'b1; bus.p1_addr = 9'h0AB;
    for (int i = 0; i < WORDS; i++) bus.mem_rd_line[i] = 32'h300 + 32'(i);
    run_txn();
    chk("post_rst_port", g_port, 1);
    chk("post_rst_cycle", g_cyc, 6);
    chk("post_rst_addr", seen_addr, 9'h0AB);
    chk("post_rst_p1_line4", bus.p1_rd_line[4], 32'h304);
    chk("post_rst_p0_line4", bus.p0_rd_line[4], 0);
    bus.p1_rd_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: LINE_ADDR_LEN, default 3, log2 of words per line; ADDR_LEN, default 9, line-address width ({tag,set}).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have, for each requester port n in {0,1}, pn_rd_req and pn_wr_req  input  1  line read / line write request, held by the requester until its grant.
REQ-005 SHALL have pn_addr  input  ADDR_LEN  line address, and pn_wr_line  input  32 x 2^LINE_ADDR_LEN (unpacked)  write-back line.
REQ-006 SHALL have pn_gnt  output  1  one-cycle completion pulse, and pn_rd_line  output  32 x 2^LINE_ADDR_LEN  read data, valid from the pn_gnt cycle until port n's next grant.
REQ-007 SHALL have mem_rd_req and mem_wr_req  output  1; mem_addr  output  ADDR_LEN; mem_wr_line  output  line; mem_gnt  input  1; mem_rd_line  input  line. These connect to main_mem.
REQ-008 SHALL have busy  output  1  high whenever the state is not IDLE.

Function
REQ-009 SHALL implement FSM IDLE -> MEM -> RESP -> IDLE, with owner register own (0/1).
REQ-010 IDLE SHALL grant a port when any of its requests is high, then move to MEM on the next edge, latching own, the operation (write if pn_wr_req, else read), pn_addr and pn_wr_line.
REQ-011 Simultaneous requests from both ports SHALL be resolved round-robin: the port not granted last wins; after reset port 0 has priority.
REQ-012 pn_rd_req and pn_wr_req both high on one port SHALL be treated as a write; the read SHALL be served only on a later grant if still asserted.
REQ-013 In MEM, registered mem_rd_req/mem_wr_req, mem_addr and mem_wr_line SHALL hold the latched values, stable until mem_gnt.
REQ-014 On an edge with mem_gnt=1 in MEM, the FSM SHALL move to RESP, drop the memory request, and latch mem_rd_line into the owner's rd_line buffer (reads only).
REQ-015 In RESP, p{own}_gnt SHALL be 1 for exactly one cycle; the other pn_gnt SHALL stay 0.
REQ-016 RESP SHALL always go to IDLE; IDLE SHALL be a mandatory turnaround cycle, so a requester's stale request is never regranted.
REQ-017 Grant latency SHALL be L+2 cycles from request sampled in IDLE to pn_gnt, where L = cycles from mem request to mem_gnt.
REQ-018 Requests arriving during MEM/RESP SHALL be ignored until IDLE; no queuing.
REQ-019 mem_addr and mem_wr_line SHALL be 0 outside MEM; a non-owner's rd_line buffer SHALL NOT change.
REQ-020 mem_gnt outside MEM SHALL be ignored.

Reset
REQ-021 rst SHALL force, on the next edge: state IDLE, own=1 (so port 0 wins next), p0_gnt=p1_gnt=0, mem_rd_req=mem_wr_req=0, mem_addr=0, mem_wr_line=0, p0_rd_line=p1_rd_line=0, busy=0.
REQ-022 rst during MEM SHALL abandon the transaction without pn_gnt; a later mem_gnt SHALL be ignored.

Configuration
REQ-023 Macro MEM_ARB_FIXED_PRIO_EN: when defined, port 0 SHALL always win simultaneous requests and own SHALL NOT affect arbitration; when undefined, round-robin per REQ-011 applies.

Verification
REQ-024 Reset, then p0_rd_req=1, p0_addr=9'h015, memory stub L=4 with line {0..7} -> mem_rd_req high 4 cycles with mem_addr=9'h015; p0_gnt at cycle 6; p0_rd_line={0..7}; p1_gnt=0.
REQ-025 p1_wr_req=1, p1_addr=9'h1A0, line all 32'hDEADBEEF -> mem_wr_req=1, mem_wr_line matches; p1_gnt at cycle 6; p1_rd_line unchanged.
REQ-026 Both ports read same cycle, held across 3 grants -> grant order p0, p1, p0 (round-robin); with MEM_ARB_FIXED_PRIO_EN, p0, p0, p0.
REQ-027 p0 write then immediate read (cache swap-out/in pattern) -> two separate grants, IDLE cycle between; no double grant on the write.
REQ-028 rst pulsed 2 cycles into MEM, stub then returns mem_gnt -> no pn_gnt, outputs at reset values, next p1 request served normally.
REQ-029 p0 sets rd_req and wr_req together -> write performed first, read served on next grant.
